// File: rtl/clk_mon.sv
// clk_mon: synchronizes an asynchronous signal, detects its edges and measures its
// period and high time in clk cycles, flagging loss when no rise arrives in TIMEOUT cycles.
// Optional high-time measurement is built only when CLK_MON_DUTY_EN is defined.
module clk_mon #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             lost,
    output logic [CNT_W-1:0] high_time
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEAS = 2'd1,
        S_LOST = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rise_q, fall_q;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   lost_q, lost_d;
    logic                   sync_lvl_c, rise_det_c, fall_det_c;

    assign sync_lvl_c = sync_q[SYNC_STAGES-1];
    assign rise_det_c = sync_lvl_c & ~hist_q;
    assign fall_det_c = ~sync_lvl_c & hist_q;

    // Measurement FSM: a rise always wins over a coincident timeout
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = valid_q;
        lost_d   = lost_q;

        if (rise_det_c) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (rise_det_c) begin
                    state_d = S_MEAS;
                end
            end
            S_MEAS: begin
                if (rise_det_c) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = S_LOST;
                    lost_d  = 1'b1;
                    valid_d = 1'b0;
                end
            end
            S_LOST: begin
                if (rise_det_c) begin
                    state_d = S_MEAS;
                    lost_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            sync_q   <= '0;
            hist_q   <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            period_q <= '0;
            valid_q  <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist_q   <= sync_lvl_c;
            cnt_q    <= cnt_d;
            rise_q   <= rise_det_c;
            fall_q   <= fall_det_c;
            period_q <= period_d;
            valid_q  <= valid_d;
            lost_q   <= lost_d;
        end
    end

    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign period       = period_q;
    assign period_valid = valid_q;
    assign lost         = lost_q;

`ifdef CLK_MON_DUTY_EN
    logic [CNT_W-1:0] high_q, high_d;

    // High time is captured only while a measurement is running
    always_comb begin
        high_d = high_q;
        if (state_q == S_MEAS && fall_det_c) begin
            high_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            high_q <= '0;
        end else begin
            high_q <= high_d;
        end
    end

    assign high_time = high_q;
`else
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_clk_mon.sv
// Bench for clk_mon: directed and random sig_in waveforms checked every cycle against an
// event-timestamp model of edge latency, period, loss and high time.
module tb_clk_mon;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned TIMEOUT     = 100;

    logic             clk = 1'b0;
    logic             rst;
    logic             sig_in;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             lost;
    logic [CNT_W-1:0] high_time;

    clk_mon #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .period      (period),
        .period_valid(period_valid),
        .lost        (lost),
        .high_time   (high_time)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    // Model: sample history plus timestamps (in clk edges) of the last reported rise
    logic [3:0] smp;
    int         last_rise;
    bit         have_prev;
    bit         lost_m;
    bit         valid_m;
    int         period_m;
    int         high_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        smp       = '0;
        last_rise = 0;
        have_prev = 1'b0;
        lost_m    = 1'b0;
        valid_m   = 1'b0;
        period_m  = 0;
        high_m    = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rise"},   32'(rise_pulse),   32'd0);
        chk({tag, "_fall"},   32'(fall_pulse),   32'd0);
        chk({tag, "_period"}, 32'(period),       32'd0);
        chk({tag, "_valid"},  32'(period_valid), 32'd0);
        chk({tag, "_lost"},   32'(lost),         32'd0);
        chk({tag, "_high"},   32'(high_time),    32'd0);
    endtask

    // Drive one level for one clk cycle, then check all outputs against the model
    task automatic step(input logic v);
        bit rise_m;
        bit fall_m;
        int high_exp;
        sig_in = v;
        @(posedge clk);
        cyc++;
        smp = {smp[2:0], sig_in};
        @(negedge clk);
        // An edge first sampled at edge e is reported after edge e+SYNC_STAGES
        rise_m = smp[2] & ~smp[3];
        fall_m = ~smp[2] & smp[3];
        if (fall_m && have_prev && !lost_m) high_m = cyc - last_rise;
        if (rise_m) begin
            if (have_prev && !lost_m) begin
                period_m = cyc - last_rise;
                valid_m  = 1'b1;
            end
            lost_m    = 1'b0;
            have_prev = 1'b1;
            last_rise = cyc;
        end else if (have_prev && !lost_m && (cyc - last_rise) == int'(TIMEOUT)) begin
            lost_m  = 1'b1;
            valid_m = 1'b0;
        end
`ifdef CLK_MON_DUTY_EN
        high_exp = high_m;
`else
        high_exp = 0;
`endif
        chk("rise_pulse",   32'(rise_pulse),   32'(rise_m));
        chk("fall_pulse",   32'(fall_pulse),   32'(fall_m));
        chk("period",       32'(period),       32'(period_m));
        chk("period_valid", 32'(period_valid), 32'(valid_m));
        chk("lost",         32'(lost),         32'(lost_m));
        chk("high_time",    32'(high_time),    32'(high_exp));
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        for (int i = 0; i < reps; i++) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    initial begin
        int per;
        int hi;

        // Reset state
        rst    = 1'b0;
        sig_in = 1'b0;
        model_reset();
        #3;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Idle with no edges, then free-running 25/25 waveform
        hold(1'b0, 4);
        wave(25, 25, 6);

        // Duty 10 high / 40 low
        wave(10, 40, 4);

        // Loss after a valid period, then recovery
        hold(1'b0, 150);
        wave(25, 25, 3);

        // Rise exactly at the timeout count, then one cycle past it
        wave(50, 50, 3);
        wave(50, 51, 1);
        wave(50, 50, 2);

        // Asynchronous reset in the middle of a measurement, released with sig_in high
        hold(1'b1, 17);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        sig_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        hold(1'b1, 12);
        hold(1'b0, 20);
        wave(15, 20, 3);

        // Random periods and duty cycles below the timeout
        for (int k = 0; k < 25; k++) begin
            per = int'($urandom_range(95, 7));
            hi  = int'($urandom_range(per - 1, 1));
            wave(hi, per - hi, 1);
        end
        hold(1'b0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
